gate_sweep_checker: RTL and testbench

//  Sequencer/checker for small combinational gate DUTs in the circuit suite.

---
 rtl/gate_sweep_pkg.sv | 18 +
 rtl/gate_sweep_checker_if.sv | 27 ++
 rtl/gate_ref_model.sv | 26 ++
 rtl/gate_sweep_checker.sv | 130 +++++++++++++
 tb/tb_gate_sweep_checker.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/gate_sweep_pkg.sv
// Shared types for the gate sweep checkers: FSM state encoding and reference op codes.
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

endpackage

// File: rtl/gate_sweep_checker_if.sv
// Bundle between the sweep checker, its controlling testbench and the gate under test.
interface gate_sweep_checker_if #(
  parameter int N_INPUTS = 2
);

  logic                start;
  logic                dut_out;
  logic [N_INPUTS-1:0] stim;
  logic                busy;
  logic                done;
  logic                pass;
  logic [N_INPUTS:0]   fail_count;
  logic [N_INPUTS-1:0] first_fail_vec;
  logic                stuck_at_0;
  logic                stuck_at_1;

  modport master (
    output start, dut_out,
    input  stim, busy, done, pass, fail_count, first_fail_vec, stuck_at_0, stuck_at_1
  );

  modport slave (
    input  start, dut_out,
    output stim, busy, done, pass, fail_count, first_fail_vec, stuck_at_0, stuck_at_1
  );

endinterface

// File: rtl/gate_ref_model.sv
// Expected output of an N-input reduction gate for a given input vector.
module gate_ref_model
  import gate_sweep_pkg::*;
#(
  parameter int N_INPUTS = 2
) (
  input  logic [2:0]          i_op,
  input  logic [N_INPUTS-1:0] i_vec,
  output logic                o_expected
);

  // Reduction selected by op code; unknown codes expect 0
  always_comb begin
    o_expected = 1'b0;
    case (i_op)
      OP_AND:  o_expected = &i_vec;
      OP_OR:   o_expected = |i_vec;
      OP_XOR:  o_expected = ^i_vec;
      OP_NAND: o_expected = ~&i_vec;
      OP_NOR:  o_expected = ~|i_vec;
      OP_XNOR: o_expected = ~^i_vec;
      default: o_expected = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_sweep_checker.sv
// Sweeps every input vector of a small gate, holds each for a settle time,
// and accumulates mismatch count, first failing vector and stuck-at flags.
module gate_sweep_checker
  import gate_sweep_pkg::*;
#(
  parameter int N_INPUTS      = 2,
  parameter int SETTLE_CYCLES = 1,
  parameter int EXPECT_OP     = 0
) (
  input logic                  clk,
  input logic                  rst,
  gate_sweep_checker_if.slave  bus
);

  localparam int                  CNT_W      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]    CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
  localparam logic [N_INPUTS:0]   VEC_ONE    = (N_INPUTS + 1)'(1);
  localparam logic [N_INPUTS:0]   VEC_LAST   = (N_INPUTS + 1)'((1 << N_INPUTS) - 1);
  localparam logic [2:0]          REF_OP     = 3'(EXPECT_OP);

  state_e              r_state;
  logic [N_INPUTS:0]   r_vec;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;
  logic [N_INPUTS:0]   r_fail_count;
  logic [N_INPUTS-1:0] r_first_fail;
  logic                r_seen0;
  logic                r_seen1;
  logic                r_stuck0;
  logic                r_stuck1;

  logic                w_expected;
  logic                w_mismatch;
  logic [N_INPUTS:0]   w_fail_next;

  gate_ref_model #(
    .N_INPUTS (N_INPUTS)
  ) u_ref (
    .i_op       (REF_OP),
    .i_vec      (r_vec[N_INPUTS-1:0]),
    .o_expected (w_expected)
  );

  assign w_mismatch  = bus.dut_out ^ w_expected;
  assign w_fail_next = r_fail_count + {{N_INPUTS{1'b0}}, w_mismatch};

  // Sweep sequencer; final sample is folded straight into the DONE results
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_vec        <= '0;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail_count <= '0;
      r_first_fail <= '0;
      r_seen0      <= 1'b0;
      r_seen1      <= 1'b0;
      r_stuck0     <= 1'b0;
      r_stuck1     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_vec        <= '0;
            r_cnt        <= CNT_RELOAD;
            r_busy       <= 1'b1;
            r_pass       <= 1'b0;
            r_fail_count <= '0;
            r_first_fail <= '0;
            r_seen0      <= 1'b0;
            r_seen1      <= 1'b0;
            r_stuck0     <= 1'b0;
            r_stuck1     <= 1'b0;
            r_state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (r_cnt == '0) begin
            r_state <= ST_SAMPLE;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        ST_SAMPLE: begin
          r_fail_count <= w_fail_next;
          if (w_mismatch && (r_fail_count == '0)) begin
            r_first_fail <= r_vec[N_INPUTS-1:0];
          end
          r_seen0 <= r_seen0 | ~bus.dut_out;
          r_seen1 <= r_seen1 | bus.dut_out;
          if (r_vec == VEC_LAST) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_pass   <= (w_fail_next == '0);
            r_stuck0 <= ~(r_seen1 | bus.dut_out);
            r_stuck1 <= ~(r_seen0 | ~bus.dut_out);
            r_state  <= ST_DONE;
          end else begin
            r_vec   <= r_vec + VEC_ONE;
            r_cnt   <= CNT_RELOAD;
            r_state <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.stim           = r_vec[N_INPUTS-1:0];
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.pass           = r_pass;
  assign bus.fail_count     = r_fail_count;
  assign bus.first_fail_vec = r_first_fail;
  assign bus.stuck_at_0     = r_stuck0;
  assign bus.stuck_at_1     = r_stuck1;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: three instances (AND/S=1, XOR/S=1, AND/S=3) driving
// gates described by random 4-entry truth tables, checked against a truth-table model.
module tb_gate_sweep_checker;

  logic       clk;
  logic       rst;
  logic       start_a [3];
  logic [3:0] tt_a    [3];
  logic       busy_a  [3];
  logic       done_a  [3];
  logic       pass_a  [3];
  logic       s0_a    [3];
  logic       s1_a    [3];
  logic [2:0] fc_a    [3];
  logic [1:0] ffv_a   [3];
  logic [1:0] stim_a  [3];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    gate_sweep_checker_if #(.N_INPUTS(2)) bus ();

    gate_sweep_checker #(
      .N_INPUTS      (2),
      .SETTLE_CYCLES (g == 2 ? 3 : 1),
      .EXPECT_OP     (g == 1 ? 2 : 0)
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    assign bus.start   = start_a[g];
    assign bus.dut_out = tt_a[g][bus.stim];
    assign busy_a[g]   = bus.busy;
    assign done_a[g]   = bus.done;
    assign pass_a[g]   = bus.pass;
    assign s0_a[g]     = bus.stuck_at_0;
    assign s1_a[g]     = bus.stuck_at_1;
    assign fc_a[g]     = bus.fail_count;
    assign ffv_a[g]    = bus.first_fail_vec;
    assign stim_a[g]   = bus.stim;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected sweep results computed straight from the truth table and the op's definition
  task automatic model(input int op, input logic [3:0] tt, output int fc, output int ffv,
                       output bit pss, output bit s0, output bit s1);
    bit seen0, seen1, r;
    int ones;
    fc = 0; ffv = 0; seen0 = 0; seen1 = 0;
    for (int v = 0; v < 4; v++) begin
      ones = $countones(v);
      case (op)
        0:       r = (ones == 2);
        1:       r = (ones > 0);
        2:       r = (ones % 2 == 1);
        3:       r = (ones != 2);
        4:       r = (ones == 0);
        5:       r = (ones % 2 == 0);
        default: r = 0;
      endcase
      if (tt[v] != r) begin
        if (fc == 0) ffv = v;
        fc++;
      end
      if (tt[v]) seen1 = 1; else seen0 = 1;
    end
    pss = (fc == 0);
    s0  = !seen1;
    s1  = !seen0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({busy_a[d], done_a[d], pass_a[d], s0_a[d], s1_a[d], fc_a[d], ffv_a[d], stim_a[d]} !== 12'd0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d got %b want 0", d,
                 {busy_a[d], done_a[d], pass_a[d], s0_a[d], s1_a[d], fc_a[d], ffv_a[d], stim_a[d]});
      end
    end
    rst = 1'b0;
  endtask

  // One full sweep on instance d with gate truth table tt; checks timing, stim order and results
  task automatic run_sweep(input int d, input logic [3:0] tt, input string name);
    int settle, op, fc, ffv, cycles, busy_cnt, stim_bad, mid_bad;
    bit pss, s0, s1, got_done;
    settle = (d == 2) ? 3 : 1;
    op     = (d == 1) ? 2 : 0;
    model(op, tt, fc, ffv, pss, s0, s1);
    @(negedge clk);
    tt_a[d] = tt;
    start_a[d] = 1'b1;
    @(negedge clk);
    start_a[d] = 1'b0;
    cycles = 0; busy_cnt = 0; stim_bad = 0; mid_bad = 0; got_done = 0;
    while (!got_done && cycles < 100) begin
      if (done_a[d]) begin
        got_done = 1;
      end else begin
        if (busy_a[d]) begin
          if (stim_a[d] !== 2'(busy_cnt / (settle + 1))) stim_bad++;
          if ({pass_a[d], s0_a[d], s1_a[d]} !== 3'b000) mid_bad++;
          busy_cnt++;
        end
        @(negedge clk);
        cycles++;
      end
    end
    checks++;
    if (!got_done) begin
      errors++;
      $display("FAIL %s done_timeout dut%0d no done within %0d cycles", name, d, cycles);
    end
    checks++;
    if (busy_cnt != 4 * (settle + 1)) begin
      errors++;
      $display("FAIL %s busy_cycles dut%0d got %0d want %0d", name, d, busy_cnt, 4 * (settle + 1));
    end
    checks++;
    if (stim_bad != 0 || mid_bad != 0) begin
      errors++;
      $display("FAIL %s sweep_order dut%0d stim_bad %0d midsweep_flags_bad %0d want 0 0", name, d, stim_bad, mid_bad);
    end
    checks++;
    if ({busy_a[d], pass_a[d], fc_a[d], ffv_a[d], s0_a[d], s1_a[d]} !== {1'b0, pss, 3'(fc), 2'(ffv), s0, s1}) begin
      errors++;
      $display("FAIL %s results dut%0d tt=%b got busy%0b pass%0b fc%0d ffv%0d s0%0b s1%0b want busy0 pass%0b fc%0d ffv%0d s0%0b s1%0b",
               name, d, tt, busy_a[d], pass_a[d], fc_a[d], ffv_a[d], s0_a[d], s1_a[d], pss, fc, ffv, s0, s1);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({done_a[d], busy_a[d], pass_a[d], fc_a[d], ffv_a[d], stim_a[d]} !== {2'b00, pss, 3'(fc), 2'(ffv), 2'd3}) begin
      errors++;
      $display("FAIL %s hold_after_done dut%0d got done%0b busy%0b pass%0b fc%0d ffv%0d stim%0d want done0 busy0 pass%0b fc%0d ffv%0d stim3",
               name, d, done_a[d], busy_a[d], pass_a[d], fc_a[d], ffv_a[d], stim_a[d], pss, fc, ffv);
    end
  endtask

  task automatic test_reset_mid();
    int cycles, dones;
    @(negedge clk);
    tt_a[0] = 4'b1000;
    start_a[0] = 1'b1;
    @(negedge clk);
    start_a[0] = 1'b0;
    cycles = 0;
    while (stim_a[0] !== 2'd2 && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
    checks++;
    if (stim_a[0] !== 2'd2) begin
      errors++;
      $display("FAIL reset_mid_reach_vec2 got stim %0d want 2", stim_a[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy_a[0], done_a[0], pass_a[0], s0_a[0], s1_a[0], fc_a[0], ffv_a[0], stim_a[0]} !== 12'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs got %b want 0",
               {busy_a[0], done_a[0], pass_a[0], s0_a[0], s1_a[0], fc_a[0], ffv_a[0], stim_a[0]});
    end
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      if (done_a[0] || busy_a[0]) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL reset_mid_no_done got %0d active cycles want 0", dones);
    end
    run_sweep(0, 4'b1000, "post_reset");
  endtask

  task automatic test_start_ignored();
    int dones, busy_n;
    @(negedge clk);
    tt_a[0] = 4'b1000;
    start_a[0] = 1'b1;
    @(negedge clk);
    start_a[0] = 1'b0;
    dones = 0; busy_n = 0;
    for (int c = 0; c < 30; c++) begin
      if (busy_a[0]) busy_n++;
      if (done_a[0]) dones++;
      start_a[0] = (c == 3) || done_a[0];
      @(negedge clk);
    end
    start_a[0] = 1'b0;
    checks++;
    if (dones != 1 || busy_n != 8) begin
      errors++;
      $display("FAIL start_ignored got dones %0d busy %0d want dones 1 busy 8", dones, busy_n);
    end
  endtask

  task automatic test_start_held();
    int tb1, td, tb2, c;
    bit prev_busy;
    @(negedge clk);
    tt_a[0] = 4'b1000;
    start_a[0] = 1'b1;
    @(negedge clk);
    tb1 = -1; td = -1; tb2 = -1; prev_busy = 0; c = 0;
    while (tb2 < 0 && c < 60) begin
      if (busy_a[0] && !prev_busy) begin
        if (tb1 < 0) tb1 = c; else tb2 = c;
      end
      if (done_a[0] && td < 0) td = c;
      prev_busy = busy_a[0];
      if (tb2 < 0) begin
        @(negedge clk);
        c++;
      end
    end
    start_a[0] = 1'b0;
    checks++;
    if (tb2 - td != 2 || tb2 - tb1 != 10) begin
      errors++;
      $display("FAIL start_held_gap got busy1@%0d done@%0d busy2@%0d want gap 2 period 10", tb1, td, tb2);
    end
    c = 0;
    while (!done_a[0] && c < 40) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (!done_a[0] || !pass_a[0]) begin
      errors++;
      $display("FAIL start_held_second_sweep got done %0b pass %0b want 1 1", done_a[0], pass_a[0]);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    int d;
    logic [3:0] tt;
    for (int i = 0; i < 9; i++) begin
      d  = $urandom_range(0, 2);
      tt = 4'($urandom);
      run_sweep(d, tt, "random");
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      start_a[d] = 1'b0;
      tt_a[d]    = 4'b0000;
    end
    test_reset();
    run_sweep(0, 4'b1000, "good_and");
    run_sweep(0, 4'b1111, "tied1");
    run_sweep(0, 4'b0000, "tied0");
    run_sweep(1, 4'b1000, "xor_ref_and_gate");
    run_sweep(2, 4'b1000, "settle3");
    test_reset_mid();
    test_start_ignored();
    test_start_held();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
